// File: rtl/nibble_serializer_if.sv
// Byte-in / nibble-out stream bundle for nibble_serializer.
// out_parity exists only when NIBBLE_SER_PARITY_EN is defined.
interface nibble_serializer_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        out_nibble;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [LevelW-1:0] level;
`ifdef NIBBLE_SER_PARITY_EN
  logic              out_parity;
`endif

  // Driver / sink side.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_nibble, out_valid, out_last, level
`ifdef NIBBLE_SER_PARITY_EN
    , input out_parity
`endif
  );

  // Serializer side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_nibble, out_valid, out_last, level
`ifdef NIBBLE_SER_PARITY_EN
    , output out_parity
`endif
  );
endinterface

// File: rtl/nibble_serializer.sv
// Byte FIFO feeding a two-nibble serializer with registered valid/ready outputs.
// Optional even parity on the nibble stream: define NIBBLE_SER_PARITY_EN.
module nibble_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSN_FIRST  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  nibble_serializer_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;
`ifdef NIBBLE_SER_PARITY_EN
  localparam int unsigned OutW = 5;
`else
  localparam int unsigned OutW = 4;
`endif

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  state_e            r_state;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [LevelW-1:0] r_level;
  logic [7:0]        r_shift;
  logic [OutW-1:0]   r_out;
  logic              r_valid;
  logic              r_last;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [7:0]        w_head;

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return MSN_FIRST ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return MSN_FIRST ? b[3:0] : b[7:4];
  endfunction

  // Parity travels in the same register as the nibble so the two never skew.
  function automatic logic [OutW-1:0] out_word(input logic [3:0] n);
`ifdef NIBBLE_SER_PARITY_EN
    return {^n, n};
`else
    return n;
`endif
  endfunction

  assign w_full = (r_level == LevelW'(FIFO_DEPTH));
  assign w_push = bus.in_valid & ~w_full;
  assign w_pop  = (r_level != '0) &
                  ((r_state == StIdle) | ((r_state == StSecond) & bus.out_ready));
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LevelW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LevelW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= StFirst;
          end
        end
        StFirst: begin
          // Entry from IDLE presents the first nibble one cycle after the pop.
          if (!r_valid) begin
            r_out   <= out_word(first_nib(r_shift));
            r_valid <= 1'b1;
            r_last  <= 1'b0;
          end else if (bus.out_ready) begin
            r_out   <= out_word(second_nib(r_shift));
            r_last  <= 1'b1;
            r_state <= StSecond;
          end
        end
        StSecond: begin
          if (bus.out_ready) begin
            if (w_pop) begin
              r_shift <= w_head;
              r_out   <= out_word(first_nib(w_head));
              r_last  <= 1'b0;
              r_state <= StFirst;
            end else begin
              r_out   <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_out   <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready   = ~w_full;
  assign bus.level      = r_level;
  assign bus.out_nibble = r_out[3:0];
  assign bus.out_valid  = r_valid;
  assign bus.out_last   = r_last;
`ifdef NIBBLE_SER_PARITY_EN
  assign bus.out_parity = r_out[4];
`endif

endmodule

// File: tb/tb_nibble_serializer.sv
// Self-checking bench for nibble_serializer: vector table plus scoreboard and corner sequences.
module tb_nibble_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serializer_if #(.FIFO_DEPTH(4)) a ();
  nibble_serializer_if #(.FIFO_DEPTH(4)) b ();

  nibble_serializer #(.FIFO_DEPTH(4), .MSN_FIRST(1'b1)) u_msn (.clk(clk), .rst(rst), .bus(a));
  nibble_serializer #(.FIFO_DEPTH(4), .MSN_FIRST(1'b0)) u_lsn (.clk(clk), .rst(rst), .bus(b));

  typedef struct packed {logic [3:0] nib; logic last;} exp_t;
  typedef struct {logic [7:0] din; logic [3:0] n0; logic [3:0] n1;} vec_t;

  exp_t       sb[$];
  vec_t       vecs[8];
  int         checks = 0;
  int         failures = 0;
  logic       hold_v = 1'b0;
  logic [3:0] hold_n;
  logic       hold_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  function automatic void expect_nibs(input logic [3:0] n0, input logic [3:0] n1);
    sb.push_back({n0, 1'b0});
    sb.push_back({n1, 1'b1});
  endfunction

  // Output monitor for the MSN-first instance: scoreboard compare and stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_v) begin
        check("stall_valid", a.out_valid, 1);
        check("stall_nibble", a.out_nibble, hold_n);
        check("stall_last", a.out_last, hold_l);
      end
      hold_v = a.out_valid && !a.out_ready;
      hold_n = a.out_nibble;
      hold_l = a.out_last;
      if (a.out_valid && a.out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_nibble");
        end else begin
          e = sb.pop_front();
          check("out_nibble", a.out_nibble, e.nib);
          check("out_last", a.out_last, e.last);
`ifdef NIBBLE_SER_PARITY_EN
          check("out_parity", a.out_parity, ^e.nib);
`endif
        end
      end
    end
  end

  // Caller sits just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [7:0] din, input logic [3:0] n0, input logic [3:0] n1);
    int t = 0;
    a.in_data  = din;
    a.in_valid = 1'b1;
    @(negedge clk);
    while (!a.in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!a.in_ready) fail_now("push_timeout");
    else expect_nibs(n0, n1);
    @(posedge clk);
    #1 a.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("drain_timeout");
      sb.delete();
    end
    repeat (2) @(negedge clk);
    check("idle_valid", a.out_valid, 0);
    check("idle_level", a.level, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    int         bubbles;
    int         n;
    logic [4:0] got [4];

    vecs[0] = '{8'hA5, 4'hA, 4'h5};
    vecs[1] = '{8'h3C, 4'h3, 4'hC};
    vecs[2] = '{8'h7E, 4'h7, 4'hE};
    vecs[3] = '{8'h36, 4'h3, 4'h6};
    vecs[4] = '{8'h00, 4'h0, 4'h0};
    vecs[5] = '{8'hFF, 4'hF, 4'hF};
    vecs[6] = '{8'h9E, 4'h9, 4'hE};
    vecs[7] = '{8'h12, 4'h1, 4'h2};

    a.in_data = '0; a.in_valid = 1'b0; a.out_ready = 1'b0;
    b.in_data = '0; b.in_valid = 1'b0; b.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_level", a.level, 0);
    check("rst_in_ready", a.in_ready, 1);
    check("rst_out_valid", a.out_valid, 0);
    check("rst_out_nibble", a.out_nibble, 0);
    check("rst_out_last", a.out_last, 0);
    check("rst_b_out_valid", b.out_valid, 0);
`ifdef NIBBLE_SER_PARITY_EN
    check("rst_out_parity", a.out_parity, 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency of a single byte into an empty FIFO.
    a.out_ready = 1'b1;
    a.in_data   = 8'hA5;
    a.in_valid  = 1'b1;
    @(negedge clk);
    check("lat_in_ready", a.in_ready, 1);
    expect_nibs(4'hA, 4'h5);
    @(posedge clk);
    #1 a.in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid_n", a.out_valid, 0);
    check("lat_level_n", a.level, 1);
    @(negedge clk);
    check("lat_valid_n1", a.out_valid, 0);
    check("lat_level_n1", a.level, 0);
    @(negedge clk);
    check("lat_valid_n2", a.out_valid, 1);
    check("lat_nibble_n2", a.out_nibble, 4'hA);
    drain();

    // Vector table, streamed back-to-back with the sink always ready.
    for (int i = 0; i < 8; i++) push(vecs[i].din, vecs[i].n0, vecs[i].n1);
    drain();

    // Fill under backpressure, refused push while full, then bubble-free drain.
    a.out_ready = 1'b0;
    push(8'h11, 4'h1, 4'h1);
    push(8'h22, 4'h2, 4'h2);
    push(8'h33, 4'h3, 4'h3);
    push(8'h44, 4'h4, 4'h4);
    push(8'h55, 4'h5, 4'h5);
    a.in_data  = 8'h66;
    a.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("full_in_ready", a.in_ready, 0);
    check("full_level", a.level, 4);
    check("full_head", a.out_nibble, 4'h1);
    @(posedge clk);
    #1 a.out_ready = 1'b1;
    push(8'h66, 4'h6, 4'h6);
    bubbles = 0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      if (sb.size() != 0 && !a.out_valid) bubbles++;
      t++;
    end
    check("no_bubbles", bubbles, 0);
    drain();

    // Sink toggling every cycle.
    a.out_ready = 1'b0;
    fork
      begin
        push(8'hF0, 4'hF, 4'h0);
        push(8'h0F, 4'h0, 4'hF);
      end
      begin
        repeat (16) begin
          @(posedge clk);
          #1 a.out_ready = ~a.out_ready;
        end
      end
    join
    a.out_ready = 1'b1;
    drain();

    // Reset while the second nibble is stalled with two bytes queued.
    a.out_ready = 1'b0;
    push(8'h9E, 4'h9, 4'hE);
    push(8'h77, 4'h7, 4'h7);
    push(8'h88, 4'h8, 4'h8);
    t = 0;
    @(negedge clk);
    while (!a.out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 a.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 a.out_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_nibble", a.out_nibble, 4'hE);
    check("pre_rst_last", a.out_last, 1);
    check("pre_rst_level", a.level, 2);
    #2 rst = 1'b1;
    hold_v = 1'b0;
    #1;
    check("mid_rst_valid", a.out_valid, 0);
    check("mid_rst_level", a.level, 0);
    check("mid_rst_in_ready", a.in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    a.out_ready = 1'b1;
    push(8'h12, 4'h1, 4'h2);
    drain();

    // LSN-first instance.
    b.out_ready = 1'b1;
    b.in_data   = 8'h3C;
    b.in_valid  = 1'b1;
    @(negedge clk);
    check("lsn_in_ready", b.in_ready, 1);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b.out_valid && b.out_ready && n < 4) begin
        got[n] = {b.out_nibble, b.out_last};
        n++;
      end
    end
    check("lsn_count", n, 2);
    check("lsn_first", got[0], {4'hC, 1'b0});
    check("lsn_second", got[1], {4'h3, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
